// File: rtl/alu_result_sel_reg.sv
// Registered N-way ALU result selector with multi-cycle wait, timeout and valid/ready output.
// Optional zero flag output enabled by defining ALU_RESULT_SEL_ZERO_FLAG_EN.
module alu_result_sel_reg #(
    parameter int WIDTH      = 32,
    parameter int NUM_OPS    = 8,
    parameter int SEL_W      = 3,
    parameter int WAIT_LIMIT = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_OPS*WIDTH-1:0] op_results,
    input  logic [NUM_OPS-1:0]       op_done,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     err
`ifdef ALU_RESULT_SEL_ZERO_FLAG_EN
    ,
    output logic                     zero
`endif
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_d;
    logic               err_d;
    logic [SEL_W-1:0]   idx;
    logic [WIDTH-1:0]   mux_result;
    logic               mux_done;
    logic               legal;
    logic               accept;

    // A new request is looked up by the live opcode; an outstanding one by the stored opcode.
    assign idx = (state == WAIT) ? sel_q : sel;

    always_comb begin
        mux_result = '0;
        mux_done   = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (idx == SEL_W'(k)) begin
                mux_result = op_results[k*WIDTH +: WIDTH];
                mux_done   = op_done[k];
            end
        end
    end

    assign legal     = ({1'b0, sel} < (SEL_W + 1)'(NUM_OPS));
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        state_d  = state;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        result_d = result;
        err_d    = err;
        case (state)
            IDLE, DONE: begin
                if ((state == DONE) && out_ready) begin
                    state_d = IDLE;
                end
                if (accept) begin
                    sel_d = sel;
                    if (!legal) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (mux_done) begin
                        result_d = mux_result;
                        err_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mux_done) begin
                    result_d = mux_result;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_d;
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            result <= result_d;
            err    <= err_d;
        end
    end

`ifdef ALU_RESULT_SEL_ZERO_FLAG_EN
    logic capture;

    // A fresh value is loaded whenever DONE is entered or re-entered through an accept.
    assign capture = (state_d == DONE) && ((state != DONE) || accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
        end else if (capture) begin
            zero <= (result_d == '0);
        end
    end
`endif

endmodule

// File: doc/alu_result_sel_reg.md
# alu_result_sel_reg

Parametrised, registered N-way result selector for the ALU output stage. It selects one of `NUM_OPS` operation results of `WIDTH` bits by opcode, waits for multi-cycle units (e.g. modulo) to report completion, and holds the selected result behind a valid/ready handshake. It sits between the per-operation functional units and the ALU result register/consumer. It replaces the single-bit, eight-way, purely combinational gate-level selector.

## Interface
Parameters:
- `WIDTH`, 32, result width in bits.
- `NUM_OPS`, 8, number of operation inputs; must satisfy 2 ≤ `NUM_OPS` ≤ 2^`SEL_W`.
- `SEL_W`, 3, opcode width.
- `WAIT_LIMIT`, 32, maximum WAIT cycles before timeout; ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_results`  in  `NUM_OPS*WIDTH`  packed results; op k occupies bits [k*WIDTH +: WIDTH].
- `op_done`  in  `NUM_OPS`  per-op result-ready; combinational units tie high.
- `sel`  in  `SEL_W`  opcode; sampled on accept.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `out_valid`  out  1  `result`/`err` valid.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `result`  out  `WIDTH`  registered selected result.
- `err`  out  1  illegal opcode or timeout; qualified by `out_valid`.
- `zero`  out  1  present only with `ALU_RESULT_SEL_ZERO_FLAG_EN`.

## Operation
- FSM states: IDLE, WAIT, DONE.
- Registered state: `sel_q`, a wait counter (`$clog2(WAIT_LIMIT+1)` bits), `result`, `err`, and `zero` when enabled.
- IDLE:
  - `in_ready`=1.
  - On accept, `sel_q`←`sel`.
  - If `sel` ≥ `NUM_OPS`: `result`←0, `err`←1, go to DONE.
  - Else if `op_done[sel]`=1 in the accept cycle: `result`←slice `sel`, `err`←0, go to DONE.
  - Else clear the counter and go to WAIT.
- WAIT:
  - `in_ready`=0; `op_results`/`op_done` are indexed by `sel_q`.
  - If `op_done[sel_q]`: capture the slice, `err`←0, go to DONE.
  - Else if counter = `WAIT_LIMIT`-1: `result`←0, `err`←1, go to DONE.
  - Otherwise counter+1.
  - Completion takes priority over timeout in the same cycle.
- DONE:
  - `out_valid`=1; `result`, `err` and `zero` are held stable until the handshake.
  - `in_ready` = `out_ready` (combinational), giving back-to-back throughput.
  - On `out_ready` with no new accept: go to IDLE.
  - On `out_ready` and `in_valid`: the new request is processed exactly as from IDLE in the same cycle (DONE→DONE or DONE→WAIT).
- Result values are passed through unmodified; no arithmetic or extension.
- `op_done` and `op_results` for non-selected ops are ignored.
- Reset values: state=IDLE, `result`=0, `err`=0, `zero`=0, `out_valid`=0, `sel_q`=0, counter=0. `in_ready` is 1 during and after reset.
- Reset asserted mid-WAIT or mid-DONE aborts the transaction; no output is produced for it.

## Timing
- Latency with `op_done` high at accept: `out_valid` rises 1 cycle after the accept edge.
- Latency with done arriving d cycles after accept (1 ≤ d < `WAIT_LIMIT`): `out_valid` rises d+1 cycles after accept.
- Timeout: `out_valid` with `err`=1 rises exactly `WAIT_LIMIT`+1 cycles after accept.
- Peak throughput: one result per cycle when `op_done` is high and `out_ready` is held high.
- `out_ready`→`in_ready` is the only combinational path. All outputs except `in_ready` are registered.

## Configuration
- `ALU_RESULT_SEL_ZERO_FLAG_EN` defined:
  - `zero` port exists.
  - `zero` ← (captured value == 0), registered alongside `result`; valid with `out_valid`.
  - `zero` = 1 on illegal-opcode or timeout results.
- Not defined: no `zero` port and no flag logic; all other behaviour is identical.

## Test plan
- Reset, then `sel`=3 with slice 3 = 0xDEADBEEF and `op_done`=all ones, `out_ready`=1 → `out_valid` 1 cycle later, `result`=0xDEADBEEF, `err`=0, `zero`=0.
- `sel`=7 with `op_done[7]` low for 5 cycles then high, slice 7 = 0x00000005 → `in_ready`=0 during WAIT; `out_valid` 6 cycles after accept with `result`=5.
- `sel`=7 with `op_done[7]` never asserted, `WAIT_LIMIT`=32 → `out_valid` at cycle 33 with `result`=0, `err`=1.
- `NUM_OPS`=6 and `sel`=6 → next cycle `out_valid`, `err`=1, `result`=0, `zero`=1 (macro on).
- Stream of 4 requests with `in_valid`=1 and `out_ready`=1 → 4 consecutive `out_valid` cycles with correct slices. Then hold `out_ready`=0 for 3 cycles → `result` stable and `in_ready`=0.
- Assert `rst_n`=0 mid-WAIT → outputs return to reset values immediately; after release, a new request with `sel`=0 completes normally.
